layer_sequencer: RTL and testbench

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

---
 rtl/layer_sequencer.sv | 120 ++++++++++++
 tb/tb_layer_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Layer sequencer: for each node, multiply-accumulates NUM_IN activation/weight
// pairs, adds the node bias, applies a ReLU clamp and writes the fixed-point result.
module layer_sequencer #(
   parameter int NUM_IN    = 5,
   parameter int NUM_NODES = 8,
   parameter int FRAC      = 13,
   localparam int AW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1,
   localparam int WW = (NUM_NODES * NUM_IN > 1) ? $clog2(NUM_NODES * NUM_IN) : 1,
   localparam int NW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] act_addr,
   output logic [WW-1:0] w_addr,
   output logic [NW-1:0] bias_addr,
   input  logic [31:0]   act_data,
   input  logic [31:0]   w_data,
   input  logic [31:0]   bias_data,
   output logic          out_we,
   output logic [NW-1:0] out_idx,
   output logic [31:0]   out_data
);

   localparam int KW = $clog2(NUM_IN + 1);

   typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

   state_t        state, state_next;
   logic [KW-1:0] k;
   logic [NW-1:0] node;
   logic [31:0]   acc;
   logic [31:0]   sum;
   logic          last_k;
   logic          last_node;

   assign last_k    = (k == KW'(NUM_IN));
   assign last_node = (node == NW'(NUM_NODES - 1));
   assign bias_addr = node;
   assign out_idx   = node;

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of the order of the statements.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k    <= '0;
         node <= '0;
         acc  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               k    <= '0;
               node <= '0;
               acc  <= '0;
            end
            MAC: begin
               k <= k + KW'(1);
               // Operand data lags its address by one cycle, so k=0 only issues.
               if (k != '0) acc <= acc + act_data * w_data;
            end
            ACT: begin
               k   <= '0;
               acc <= '0;
               if (!last_node) node <= node + NW'(1);
            end
            DONE: begin
               k <= '0;
            end
            default: ;
         endcase
      end
   end

   // NOTE: every output and next-state value gets a default first, so no path
   // through the case leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      out_we     = 1'b0;
      out_data   = '0;
      act_addr   = '0;
      w_addr     = '0;
      sum        = acc + bias_data;

      unique case (state)
         IDLE: begin
            if (start) state_next = MAC;
         end
         MAC: begin
            busy = 1'b1;
            if (k < KW'(NUM_IN)) begin
               act_addr = AW'(k);
               w_addr   = WW'(node) * WW'(NUM_IN) + WW'(k);
            end
            if (last_k) state_next = ACT;
         end
         ACT: begin
            busy   = 1'b1;
            out_we = 1'b1;
            // ReLU: negative sums clamp to zero, otherwise take the 16-bit field.
            if (!sum[31]) out_data = {16'h0000, sum[FRAC+15:FRAC]};
            state_next = last_node ? DONE : MAC;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: directed passes push expected results,
// an independent monitor pops and compares them on every out_we strobe.
module tb_layer_sequencer;

   localparam int NUM_IN    = 5;
   localparam int NUM_NODES = 8;
   localparam int FRAC      = 13;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, out_we;
   logic [2:0]  act_addr;
   logic [5:0]  w_addr;
   logic [2:0]  bias_addr, out_idx;
   logic [31:0] act_data, w_data, bias_data, out_data;

   logic [31:0] act_mem  [NUM_IN];
   logic [31:0] w_mem    [NUM_NODES*NUM_IN];
   logic [31:0] bias_mem [NUM_NODES];

   typedef struct {
      int          idx;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   compared = 0, mismatched = 0;
   int   done_count = 0, done_cyc = 0, cyc = 0;

   layer_sequencer #(.NUM_IN(NUM_IN), .NUM_NODES(NUM_NODES), .FRAC(FRAC)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .act_addr(act_addr), .w_addr(w_addr), .bias_addr(bias_addr),
      .act_data(act_data), .w_data(w_data), .bias_data(bias_data),
      .out_we(out_we), .out_idx(out_idx), .out_data(out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memories with one-cycle read latency for operands, combinational bias.
   always @(posedge clk) begin
      act_data <= act_mem[act_addr];
      w_data   <= w_mem[w_addr];
   end
   assign bias_data = bias_mem[bias_addr];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at cycle %0d",
                  name, got, got, want, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (out_we) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_strobe: got out_idx %0d out_data %0d, expected no strobe",
                        out_idx, out_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("out_idx", 32'(out_idx), e.idx);
               check("out_data", out_data, e.data);
            end
         end
         if (done) begin
            done_count++;
            done_cyc = cyc;
            check("busy_in_done", 32'(busy), 32'd0);
         end
      end
   end

   task automatic fill(input logic [31:0] a, input logic [31:0] w, input logic [31:0] b);
      for (int i = 0; i < NUM_IN; i++) act_mem[i] = a;
      for (int i = 0; i < NUM_NODES*NUM_IN; i++) w_mem[i] = w;
      for (int i = 0; i < NUM_NODES; i++) bias_mem[i] = b;
   endtask

   task automatic expect_all(input logic [31:0] d);
      for (int i = 0; i < NUM_NODES; i++) sb.push_back('{idx: i, data: d});
   endtask

   task automatic pulse_start(output int t0);
      @(posedge clk); #1 start = 1'b1; t0 = cyc;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input string name);
      int n = 0;
      while (done_count == d0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(name, done_count, d0 + 1);
   endtask

   task automatic run_pass(input string name);
      int t0, d0;
      d0 = done_count;
      pulse_start(t0);
      wait_done(d0, {name, "_done_seen"});
      check({name, "_done_latency"}, done_cyc - t0, 57);
      repeat (3) @(negedge clk);
      check({name, "_sb_drained"}, sb.size(), 0);
      check({name, "_done_once"}, done_count, d0 + 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, d0, d1, dc1, n;
      fill(32'd8192, 32'd8192, 32'd0);

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_out_we", 32'(out_we), 0);
      check("rst_out_idx", 32'(out_idx), 0);
      check("rst_out_data", out_data, 0);
      check("rst_addrs", {23'd0, act_addr, w_addr}, 0);
      @(posedge clk); #1 reset = 1'b0;

      // Nominal pass, including first-strobe latency
      expect_all(32'd40960);
      d0 = done_count;
      pulse_start(t0);
      n = 0;
      do begin @(negedge clk); n++; end while (!out_we && n < 20);
      check("first_we_latency", cyc - t0, 7);
      wait_done(d0, "p1_done_seen");
      check("p1_done_latency", done_cyc - t0, 57);
      repeat (3) @(negedge clk);
      check("p1_sb_drained", sb.size(), 0);

      // All negative weights: ReLU clamps every node to zero
      fill(32'd8192, -32'sd8192, 32'd0);
      expect_all(32'd0);
      run_pass("relu");

      // Node 2 products cancel, bias bit 29 falls outside the output field
      fill(32'd8192, 32'd8192, 32'd0);
      w_mem[10] = 32'd8192;  w_mem[11] = -32'sd8192;
      w_mem[12] = 32'd8192;  w_mem[13] = -32'sd8192;
      w_mem[14] = 32'd0;
      bias_mem[2] = 32'h2000_2000;
      for (int i = 0; i < NUM_NODES; i++)
         sb.push_back('{idx: i, data: (i == 2) ? 32'd1 : 32'd40960});
      run_pass("trunc");

      // Start pulses while busy are ignored
      fill(32'd8192, 32'd8192, 32'd0);
      expect_all(32'd40960);
      d0 = done_count;
      pulse_start(t0);
      repeat (2) @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (16) @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(d0, "busy_start_done_seen");
      check("busy_start_done_latency", done_cyc - t0, 57);
      repeat (70) @(negedge clk);
      check("busy_start_sb_drained", sb.size(), 0);
      check("busy_start_done_once", done_count, d0 + 1);

      // Reset during node 3 MAC aborts the pass
      for (int i = 0; i < 3; i++) sb.push_back('{idx: i, data: 32'd40960});
      d0 = done_count;
      pulse_start(t0);
      repeat (23) @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("abort_busy", 32'(busy), 0);
      check("abort_out_idx", 32'(out_idx), 0);
      check("abort_w_addr", 32'(w_addr), 0);
      repeat (80) @(negedge clk);
      check("abort_no_done", done_count, d0);
      check("abort_sb_drained", sb.size(), 0);
      expect_all(32'd40960);
      run_pass("after_abort");

      // Products wrap to zero; output comes from bias only
      fill(32'h0001_0000, 32'h0001_0000, 32'd0);
      for (int i = 0; i < NUM_NODES - 1; i++) bias_mem[i] = (i + 1) << FRAC;
      bias_mem[NUM_NODES-1] = 32'hFFFF_0000;
      for (int i = 0; i < NUM_NODES; i++)
         sb.push_back('{idx: i, data: (i == NUM_NODES - 1) ? 32'd0 : 32'(i + 1)});
      run_pass("wrap");

      // Start held high: next pass begins in the IDLE cycle after DONE
      fill(32'd8192, 32'd8192, 32'd0);
      expect_all(32'd40960);
      expect_all(32'd40960);
      d0 = done_count;
      @(posedge clk); #1 start = 1'b1; t0 = cyc;
      wait_done(d0, "held_done1_seen");
      check("held_done1_latency", done_cyc - t0, 57);
      d1  = done_count;
      dc1 = done_cyc;
      repeat (10) @(posedge clk); #1 start = 1'b0;
      wait_done(d1, "held_done2_seen");
      check("held_done_period", done_cyc - dc1, 58);
      repeat (70) @(negedge clk);
      check("held_sb_drained", sb.size(), 0);
      check("held_done_twice", done_count, d0 + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
